// File: rtl/ifu_cache_ctrl_if.sv
// Shared IFU types and the fetch/memory handshake bundle of the instruction-cache controller.
// Every *_valid/*_ready pair transfers on a clock edge where both are 1; valid never waits for ready.
package ifu_pkg;
  parameter int WAYS_NUM = 16;

  typedef struct packed {
    logic update_tree;
    logic update_counter;
  } t_cache_ctrl2_plru;
endpackage

interface ifu_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              core_req_valid;
  logic              core_req_ready;
  logic [ADDR_W-1:0] core_req_addr;
  logic              core_rsp_valid;
  logic              core_rsp_ready;
  logic [31:0]       core_rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_data;

  // slave: the cache controller; master: fetch stage plus memory.
  modport slave (
    input  core_req_valid, core_req_addr, core_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output core_req_ready, core_rsp_valid, core_rsp_data,
    output mem_req_valid, mem_req_addr
  );

  modport master (
    output core_req_valid, core_req_addr, core_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  core_req_ready, core_rsp_valid, core_rsp_data,
    input  mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/ifu_cache_ctrl.sv
// Fully associative instruction-cache controller: tag lookup, line fill on miss,
// and hit/fill notifications to the PLRU, which in turn supplies the victim way.
module ifu_cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  ifu_cache_ctrl_if.slave                      bus,
  output ifu_pkg::t_cache_ctrl2_plru           cache_ctrl2_plru,
  output logic                                 cache_miss,
  output logic [$clog2(ifu_pkg::WAYS_NUM)-1:0] hit_cl,
  input  logic [$clog2(ifu_pkg::WAYS_NUM)-1:0] evicted_cl,
  output logic [2:0]                           o_dbg_state
);
  localparam int WAYS  = ifu_pkg::WAYS_NUM;
  localparam int IDX_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int WSEL_W = OFFSET_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_RESP
  } t_state;

  t_state              r_state;
  t_state              w_next;
  logic [ADDR_W-1:2]   r_req_addr;
  logic [WAYS-1:0]     r_valid;
  logic [TAG_W-1:0]    r_tag  [WAYS];
  logic [LINE_W-1:0]   r_data [WAYS];
  logic [31:0]         r_rsp_data;
  logic [IDX_W-1:0]    r_hit_cl;

  logic [TAG_W-1:0]    w_req_tag;
  logic [WSEL_W-1:0]   w_word_idx;
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_way;
  logic [31:0]         w_hit_word;
  logic [31:0]         w_fill_word;
  logic                w_lookup_hit;
  logic                w_fill;

  assign w_req_tag   = r_req_addr[ADDR_W-1:OFFSET_W];
  assign w_word_idx  = r_req_addr[OFFSET_W-1:2];
  assign w_hit_word  = r_data[w_hit_way][{w_word_idx, 5'b0} +: 32];
  assign w_fill_word = bus.mem_rsp_data[{w_word_idx, 5'b0} +: 32];

  // Fills only happen on a miss, so at most one way can match.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (r_valid[i] && (r_tag[i] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = IDX_W'(i);
      end
    end
  end

  assign w_lookup_hit = (r_state == S_LOOKUP) && w_hit;
  assign w_fill       = (r_state == S_MISS_WAIT) && bus.mem_rsp_valid;

  always_comb begin
    w_next                          = r_state;
    bus.core_req_ready              = 1'b0;
    bus.core_rsp_valid              = 1'b0;
    bus.mem_req_valid               = 1'b0;
    cache_miss                      = 1'b0;
    cache_ctrl2_plru.update_tree    = 1'b0;
    cache_ctrl2_plru.update_counter = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.core_req_ready = 1'b1;
        if (bus.core_req_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        cache_ctrl2_plru.update_tree = w_hit;
        w_next = w_hit ? S_RESP : S_MISS_REQ;
      end
      S_MISS_REQ: begin
        cache_miss        = 1'b1;
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_next = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        cache_miss = 1'b1;
        if (bus.mem_rsp_valid) begin
          cache_ctrl2_plru.update_tree    = 1'b1;
          cache_ctrl2_plru.update_counter = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        bus.core_rsp_valid = 1'b1;
        if (bus.core_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req_addr <= '0;
      r_valid    <= '0;
      r_rsp_data <= '0;
      r_hit_cl   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && bus.core_req_valid) r_req_addr <= bus.core_req_addr[ADDR_W-1:2];
      if (w_lookup_hit) begin
        r_rsp_data <= w_hit_word;
        r_hit_cl   <= w_hit_way;
      end
      if (w_fill) begin
        r_valid[evicted_cl] <= 1'b1;
        r_rsp_data          <= w_fill_word;
      end
    end
  end

  // Tag and data storage carries no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[evicted_cl]  <= w_req_tag;
      r_data[evicted_cl] <= bus.mem_rsp_data;
    end
  end

  // hit_cl must accompany the update_tree pulse in the lookup cycle itself.
  assign hit_cl            = w_lookup_hit ? w_hit_way : r_hit_cl;
  assign bus.mem_req_addr  = {w_req_tag, {OFFSET_W{1'b0}}};
  assign bus.core_rsp_data = r_rsp_data;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_ifu_cache_ctrl.sv
// Directed and random fetch traffic against an array-level cache model; the bench plays
// fetch stage, memory and PLRU (it chooses evicted_cl).
module tb_ifu_cache_ctrl;
  import ifu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_cache_ctrl_if #(.ADDR_W(32), .LINE_W(128)) bus ();
  t_cache_ctrl2_plru plru_o;
  logic              cache_miss;
  logic [3:0]        hit_cl;
  logic [3:0]        evicted_cl;
  logic [2:0]        dbg_state;

  ifu_cache_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .cache_ctrl2_plru (plru_o),
    .cache_miss       (cache_miss),
    .hit_cl           (hit_cl),
    .evicted_cl       (evicted_cl),
    .o_dbg_state      (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0]  exp_q[$];
  logic         m_valid [16];
  logic [27:0]  m_tag   [16];
  logic [127:0] m_line  [16];

  int n_upd_cnt = 0, n_upd_tree = 0, n_mem_hs = 0, n_rsp_hs = 0;

  // Event monitor sampled mid-cycle, after the negedge drives have settled.
  always begin
    @(negedge clk);
    #2;
    if (plru_o.update_counter) n_upd_cnt++;
    if (plru_o.update_tree) n_upd_tree++;
    if (bus.mem_req_valid && bus.mem_req_ready) n_mem_hs++;
    if (bus.core_rsp_valid && bus.core_rsp_ready) n_rsp_hs++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_find(input logic [31:0] a);
    int w = -1;
    for (int i = 0; i < 16; i++)
      if (m_valid[i] && m_tag[i] == a[31:4]) w = i;
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_req_ready"}, bus.core_req_ready, 1);
    check({p, "_rsp_valid"}, bus.core_rsp_valid, 0);
    check({p, "_mem_req_valid"}, bus.mem_req_valid, 0);
    check({p, "_update_tree"}, plru_o.update_tree, 0);
    check({p, "_update_counter"}, plru_o.update_counter, 0);
    check({p, "_cache_miss"}, cache_miss, 0);
    check({p, "_hit_cl"}, hit_cl, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [3:0] victim, input logic [127:0] line,
                        input int mem_stall, input int rsp_stall);
    int           way;
    logic [127:0] exp_line;
    logic [31:0]  exp_word;
    logic [31:0]  exp_maddr;
    int           c_upd, c_tree, c_mem, c_rsp;
    way       = model_find(addr);
    exp_line  = (way >= 0) ? m_line[way] : line;
    exp_word  = exp_line[{addr[3:2], 5'b0} +: 32];
    exp_maddr = {addr[31:4], 4'h0};
    exp_q.push_back(exp_word);
    c_upd = n_upd_cnt; c_tree = n_upd_tree; c_mem = n_mem_hs; c_rsp = n_rsp_hs;

    @(negedge clk);
    check("req_ready", bus.core_req_ready, 1);
    bus.core_req_valid = 1'b1;
    bus.core_req_addr  = addr;
    @(negedge clk);
    bus.core_req_valid = 1'b0;
    bus.core_req_addr  = $urandom;
    check("lookup_rsp_valid", bus.core_rsp_valid, 0);
    check("lookup_cache_miss", cache_miss, 0);
    if (way >= 0) begin
      check("hit_update_tree", plru_o.update_tree, 1);
      check("hit_cl", hit_cl, way[3:0]);
      check("hit_mem_req_valid", bus.mem_req_valid, 0);
      @(negedge clk);
    end else begin
      check("miss_lookup_tree", plru_o.update_tree, 0);
      @(negedge clk);
      check("miss_mem_req_valid", bus.mem_req_valid, 1);
      check("miss_mem_req_addr", bus.mem_req_addr, exp_maddr);
      check("miss_cache_miss", cache_miss, 1);
      repeat (mem_stall) begin
        @(negedge clk);
        check("stall_mem_req_valid", bus.mem_req_valid, 1);
        check("stall_mem_req_addr", bus.mem_req_addr, exp_maddr);
      end
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      check("wait_mem_req_valid", bus.mem_req_valid, 0);
      check("wait_cache_miss", cache_miss, 1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("wait_no_update", plru_o.update_tree, 0);
      end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = line;
      evicted_cl        = victim;
      #1;
      check("fill_update_counter", plru_o.update_counter, 1);
      check("fill_update_tree", plru_o.update_tree, 1);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
      evicted_cl        = 4'($urandom_range(0, 15));
      m_valid[victim] = 1'b1;
      m_tag[victim]   = addr[31:4];
      m_line[victim]  = line;
    end

    exp_word = exp_q.pop_front();
    check("rsp_valid", bus.core_rsp_valid, 1);
    check("rsp_data", bus.core_rsp_data, exp_word);
    repeat (rsp_stall) begin
      @(negedge clk);
      check("stall_rsp_valid", bus.core_rsp_valid, 1);
      check("stall_rsp_data", bus.core_rsp_data, exp_word);
    end
    bus.core_rsp_ready = 1'b1;
    @(negedge clk);
    bus.core_rsp_ready = 1'b0;
    check("post_rsp_valid", bus.core_rsp_valid, 0);
    check("post_req_ready", bus.core_req_ready, 1);
    check("n_update_counter", n_upd_cnt - c_upd, (way >= 0) ? 0 : 1);
    check("n_update_tree", n_upd_tree - c_tree, 1);
    check("n_mem_handshake", n_mem_hs - c_mem, (way >= 0) ? 0 : 1);
    check("n_rsp_handshake", n_rsp_hs - c_rsp, 1);
  endtask

  initial begin
    logic [127:0] line_a;
    rst                = 1'b0;
    bus.core_req_valid = 1'b0;
    bus.core_req_addr  = '0;
    bus.core_rsp_ready = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    evicted_cl         = '0;
    model_clear();
    #1 check_reset_outputs("init");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Cold miss then hit on the same line.
    do_req(32'h0000_1004, 4'd0, 128'h44443333_22221111_DEADBEEF_00000000, 0, 0);
    do_req(32'h0000_100C, 4'd0, '0, 0, 0);

    // Fill all 16 ways, evict way 0, re-request the evicted line.
    do_reset();
    for (int i = 0; i < 16; i++)
      do_req(32'h0000_1000 + 32'(i * 16), 4'(i), {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    do_req(32'h0000_2000, 4'd0, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    do_req(32'h0000_1008, 4'd1, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    do_req(32'h0000_1014, 4'd1, '0, 0, 0);

    // Memory and core back-pressure.
    do_req(32'h0000_7008, 4'd2, {$urandom, $urandom, $urandom, $urandom}, 5, 3);

    // Reset while waiting for the fill.
    @(negedge clk);
    bus.core_req_valid = 1'b1;
    bus.core_req_addr  = 32'h0000_5008;
    @(negedge clk);
    bus.core_req_valid = 1'b0;
    @(negedge clk);
    check("r5_mem_req_valid", bus.mem_req_valid, 1);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("r5_wait_cache_miss", cache_miss, 1);
    rst = 1'b0;
    #1 check_reset_outputs("midmiss");
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = {4{32'hBAD0_BAD0}};
    evicted_cl        = 4'd5;
    #1;
    check("late_rsp_tree", plru_o.update_tree, 0);
    check("late_rsp_counter", plru_o.update_counter, 0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    do_req(32'h0000_5008, 4'd5, {$urandom, $urandom, $urandom, $urandom}, 0, 0);

    // Spurious fill data while idle must not disturb a resident line.
    line_a = {$urandom, $urandom, $urandom, $urandom};
    do_req(32'h0000_6000, 4'd3, line_a, 0, 0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = ~line_a;
    evicted_cl        = 4'd3;
    #1;
    check("idle_rsp_tree", plru_o.update_tree, 0);
    check("idle_rsp_counter", plru_o.update_counter, 0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    do_req(32'h0000_6004, 4'd0, '0, 0, 0);

    // Random traffic over a small address pool so hits and evictions mix.
    for (int n = 0; n < 40; n++)
      do_req(32'h0000_3000 | 32'($urandom_range(0, 23) << 4) | 32'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
             $urandom_range(0, 2), $urandom_range(0, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
